// File: rtl/hsi_mse_pkg.sv
// Shared constants and types for the squared-difference accumulator block.
//   HM_DATA_WIDTH        : sample width
//   HM_DATA_WIDTH_MUL    : squared-difference (product) width
//   HM_DATA_WIDTH_ACC    : accumulator width
//   HM_VECTOR_LEN_WIDTH  : vector-length / counter width
//   HM_SQ_DF_ACC_STAGES  : pipeline depth of sq_df_acc
//   ST_*                 : controller state encodings
package hsi_mse_pkg;

  localparam int HM_DATA_WIDTH       = 16;
  localparam int HM_DATA_WIDTH_MUL   = 32;
  localparam int HM_DATA_WIDTH_ACC   = 40;
  localparam int HM_VECTOR_LEN_WIDTH = 8;
  localparam int HM_SQ_DF_ACC_STAGES = 3;
  localparam int HM_FLUSH_CNT_WIDTH  = 2;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_FEED  = 3'd1;
  localparam logic [2:0] ST_DRAIN = 3'd2;
  localparam logic [2:0] ST_DONE  = 3'd3;
  localparam logic [2:0] ST_FLUSH = 3'd4;

  typedef enum logic [2:0] {
    SQ_IDLE  = ST_IDLE,
    SQ_FEED  = ST_FEED,
    SQ_DRAIN = ST_DRAIN,
    SQ_DONE  = ST_DONE,
    SQ_FLUSH = ST_FLUSH
  } sq_df_acc_ctrl_state_t;

endpackage

// File: rtl/sq_df_acc_ctrl_if.sv
// Job/sample/result bundle of sq_df_acc_ctrl.
//   master : job issuer (drives start, samples, result_ready, abort)
//   slave  : controller (drives in_ready, result, result_valid, busy)
interface sq_df_acc_ctrl_if #(
  parameter int DATA_WIDTH     = hsi_mse_pkg::HM_DATA_WIDTH,
  parameter int DATA_WIDTH_ACC = hsi_mse_pkg::HM_DATA_WIDTH_ACC,
  parameter int LEN_WIDTH      = hsi_mse_pkg::HM_VECTOR_LEN_WIDTH
);
  logic                      start;
  logic [LEN_WIDTH-1:0]      vector_length;
  logic [DATA_WIDTH_ACC-1:0] init_acc;
  logic                      abort;
  logic                      in_valid;
  logic                      in_ready;
  logic [DATA_WIDTH-1:0]     in_v1;
  logic [DATA_WIDTH-1:0]     in_v2;
  logic                      result_valid;
  logic                      result_ready;
  logic [DATA_WIDTH_ACC-1:0] result;
  logic                      busy;

  modport master (
    output start, vector_length, init_acc, abort, in_valid, in_v1, in_v2, result_ready,
    input  in_ready, result_valid, result, busy
  );

  modport slave (
    input  start, vector_length, init_acc, abort, in_valid, in_v1, in_v2, result_ready,
    output in_ready, result_valid, result, busy
  );
endinterface

// File: rtl/sq_df_acc_ctrl_sq_df_acc.sv
// sq_df_acc: 3-stage squared-difference accumulator.
//   stage 1: |v1 - v2|, stage 2: square, stage 3: accumulate (or seed+square).
//   Ports: clk, rst_n, data_in_valid, v1, v2, initial_acc_en, initial_acc,
//          data_out_valid, data_out (running accumulator).
module sq_df_acc
  import hsi_mse_pkg::*;
#(
  parameter int DATA_WIDTH     = HM_DATA_WIDTH,
  parameter int DATA_WIDTH_MUL = HM_DATA_WIDTH_MUL,
  parameter int DATA_WIDTH_ACC = HM_DATA_WIDTH_ACC
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      data_in_valid,
  input  logic [DATA_WIDTH-1:0]     v1,
  input  logic [DATA_WIDTH-1:0]     v2,
  input  logic                      initial_acc_en,
  input  logic [DATA_WIDTH_ACC-1:0] initial_acc,
  output logic                      data_out_valid,
  output logic [DATA_WIDTH_ACC-1:0] data_out
);
  logic                      s1_valid_q, s1_valid_d;
  logic [DATA_WIDTH-1:0]     s1_diff_q, s1_diff_d;
  logic                      s1_init_en_q, s1_init_en_d;
  logic [DATA_WIDTH_ACC-1:0] s1_init_q, s1_init_d;
  logic                      s2_valid_q, s2_valid_d;
  logic [DATA_WIDTH_MUL-1:0] s2_sq_q, s2_sq_d;
  logic                      s2_init_en_q, s2_init_en_d;
  logic [DATA_WIDTH_ACC-1:0] s2_init_q, s2_init_d;
  logic                      s3_valid_q, s3_valid_d;
  logic [DATA_WIDTH_ACC-1:0] acc_q, acc_d;

  // Next-state for all three pipeline stages; the seed travels with its sample.
  always_comb begin
    s1_valid_d   = data_in_valid;
    s1_init_en_d = initial_acc_en;
    s1_init_d    = initial_acc;
    // Absolute difference keeps the square unsigned.
    if (v1 >= v2) begin
      s1_diff_d = v1 - v2;
    end else begin
      s1_diff_d = v2 - v1;
    end
    s2_valid_d   = s1_valid_q;
    s2_init_en_d = s1_init_en_q;
    s2_init_d    = s1_init_q;
    s2_sq_d      = DATA_WIDTH_MUL'(s1_diff_q) * DATA_WIDTH_MUL'(s1_diff_q);
    s3_valid_d   = s2_valid_q;
    if (s2_valid_q) begin
      // Wraps modulo 2^DATA_WIDTH_ACC by design.
      if (s2_init_en_q) begin
        acc_d = s2_init_q + DATA_WIDTH_ACC'(s2_sq_q);
      end else begin
        acc_d = acc_q + DATA_WIDTH_ACC'(s2_sq_q);
      end
    end else begin
      acc_d = acc_q;
    end
  end

  // Pipeline registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q   <= 1'b0;
      s1_diff_q    <= '0;
      s1_init_en_q <= 1'b0;
      s1_init_q    <= '0;
      s2_valid_q   <= 1'b0;
      s2_sq_q      <= '0;
      s2_init_en_q <= 1'b0;
      s2_init_q    <= '0;
      s3_valid_q   <= 1'b0;
      acc_q        <= '0;
    end else begin
      s1_valid_q   <= s1_valid_d;
      s1_diff_q    <= s1_diff_d;
      s1_init_en_q <= s1_init_en_d;
      s1_init_q    <= s1_init_d;
      s2_valid_q   <= s2_valid_d;
      s2_sq_q      <= s2_sq_d;
      s2_init_en_q <= s2_init_en_d;
      s2_init_q    <= s2_init_d;
      s3_valid_q   <= s3_valid_d;
      acc_q        <= acc_d;
    end
  end

  assign data_out_valid = s3_valid_q;
  assign data_out       = acc_q;
endmodule

// File: rtl/sq_df_acc_ctrl.sv
// sq_df_acc_ctrl: job controller around one sq_df_acc pipeline.
// Accepts a job (length, seed), streams sample pairs into the pipeline,
// counts pipeline outputs, and presents the final accumulator as result.
//   clk, rst_n : clock, async active-low reset
//   bus        : job/sample/result bundle (slave side)
// All bus outputs are registered.
module sq_df_acc_ctrl
  import hsi_mse_pkg::*;
#(
  parameter int DATA_WIDTH     = HM_DATA_WIDTH,
  parameter int DATA_WIDTH_MUL = HM_DATA_WIDTH_MUL,
  parameter int DATA_WIDTH_ACC = HM_DATA_WIDTH_ACC,
  parameter int LEN_WIDTH      = HM_VECTOR_LEN_WIDTH
) (
  input  logic            clk,
  input  logic            rst_n,
  sq_df_acc_ctrl_if.slave bus
);
  localparam logic [HM_FLUSH_CNT_WIDTH-1:0] FLUSH_LAST =
    HM_FLUSH_CNT_WIDTH'(HM_SQ_DF_ACC_STAGES - 1);

  logic [2:0]                    state_q, state_d;
  logic [LEN_WIDTH-1:0]          len_q, len_d;
  logic [DATA_WIDTH_ACC-1:0]     init_q, init_d;
  logic [LEN_WIDTH-1:0]          in_cnt_q, in_cnt_d;
  logic [LEN_WIDTH-1:0]          out_cnt_q, out_cnt_d;
  logic [HM_FLUSH_CNT_WIDTH-1:0] flush_cnt_q, flush_cnt_d;
  logic [DATA_WIDTH_ACC-1:0]     result_q, result_d;
  logic                          in_ready_q, in_ready_d;
  logic                          busy_q, busy_d;
  logic                          result_valid_q, result_valid_d;

  logic                          transfer_s;
  logic                          dp_init_en_s;
  logic                          dp_out_valid_s;
  logic [DATA_WIDTH_ACC-1:0]     dp_data_out_s;
  logic                          last_in_s;
  logic                          last_out_s;

  sq_df_acc #(
    .DATA_WIDTH     (DATA_WIDTH),
    .DATA_WIDTH_MUL (DATA_WIDTH_MUL),
    .DATA_WIDTH_ACC (DATA_WIDTH_ACC)
  ) u_sq_df_acc (
    .clk            (clk),
    .rst_n          (rst_n),
    .data_in_valid  (transfer_s),
    .v1             (bus.in_v1),
    .v2             (bus.in_v2),
    .initial_acc_en (dp_init_en_s),
    .initial_acc    (init_q),
    .data_out_valid (dp_out_valid_s),
    .data_out       (dp_data_out_s)
  );

  // FSM, counters, result capture and registered-output next values.
  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    init_d      = init_q;
    in_cnt_d    = in_cnt_q;
    out_cnt_d   = out_cnt_q;
    flush_cnt_d = flush_cnt_q;
    result_d    = result_q;

    // in_ready_q is high exactly in FEED, so this is the FEED handshake.
    transfer_s   = in_ready_q & bus.in_valid;
    dp_init_en_s = transfer_s & (in_cnt_q == '0);
    last_in_s    = (in_cnt_q == (len_q - LEN_WIDTH'(1'b1)));
    last_out_s   = (out_cnt_q == (len_q - LEN_WIDTH'(1'b1)));

    case (state_q)
      ST_IDLE: begin
        // abort beats start; zero-length jobs are ignored.
        if (bus.start && !bus.abort && (bus.vector_length != '0)) begin
          state_d   = ST_FEED;
          len_d     = bus.vector_length;
          init_d    = bus.init_acc;
          in_cnt_d  = '0;
          out_cnt_d = '0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_FEED, ST_DRAIN: begin
        if (bus.abort) begin
          state_d     = ST_FLUSH;
          in_cnt_d    = '0;
          out_cnt_d   = '0;
          flush_cnt_d = '0;
        end else begin
          if (transfer_s) begin
            in_cnt_d = in_cnt_q + LEN_WIDTH'(1'b1);
            if (last_in_s) begin
              state_d = ST_DRAIN;
            end else begin
              state_d = state_q;
            end
          end else begin
            in_cnt_d = in_cnt_q;
          end
          // Final pipeline pulse can only follow the last transfer, so it
          // never collides with the FEED->DRAIN move above.
          if (dp_out_valid_s) begin
            if (last_out_s) begin
              result_d  = dp_data_out_s;
              state_d   = ST_DONE;
              out_cnt_d = '0;
            end else begin
              out_cnt_d = out_cnt_q + LEN_WIDTH'(1'b1);
            end
          end else begin
            out_cnt_d = out_cnt_q;
          end
        end
      end
      ST_DONE: begin
        if (bus.abort || bus.result_ready) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DONE;
        end
      end
      ST_FLUSH: begin
        // Lets every in-flight sample leave the pipeline unobserved.
        if (flush_cnt_q == FLUSH_LAST) begin
          state_d     = ST_IDLE;
          flush_cnt_d = '0;
        end else begin
          flush_cnt_d = flush_cnt_q + HM_FLUSH_CNT_WIDTH'(1'b1);
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    in_ready_d     = (state_d == ST_FEED);
    busy_d         = (state_d != ST_IDLE);
    result_valid_d = (state_d == ST_DONE);
  end

  // Controller state and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      len_q          <= '0;
      init_q         <= '0;
      in_cnt_q       <= '0;
      out_cnt_q      <= '0;
      flush_cnt_q    <= '0;
      result_q       <= '0;
      in_ready_q     <= 1'b0;
      busy_q         <= 1'b0;
      result_valid_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      len_q          <= len_d;
      init_q         <= init_d;
      in_cnt_q       <= in_cnt_d;
      out_cnt_q      <= out_cnt_d;
      flush_cnt_q    <= flush_cnt_d;
      result_q       <= result_d;
      in_ready_q     <= in_ready_d;
      busy_q         <= busy_d;
      result_valid_q <= result_valid_d;
    end
  end

  assign bus.in_ready     = in_ready_q;
  assign bus.busy         = busy_q;
  assign bus.result_valid = result_valid_q;
  assign bus.result       = result_q;
endmodule

// File: tb/tb_sq_df_acc_ctrl.sv
// Directed + table-driven bench for sq_df_acc_ctrl.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_sq_df_acc_ctrl;
  import hsi_mse_pkg::*;

  typedef struct {
    logic [7:0]  len;
    logic [39:0] init;
    logic [15:0] v1 [16];
    logic [15:0] v2 [16];
    int          stall;   // 0 none, 1 toggle, 2 random
    int          hold;    // cycles result_ready stays low in DONE
    logic [39:0] exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_pass = 0;
  int   n_total = 0;
  vec_t vecs [5];

  sq_df_acc_ctrl_if bus ();

  sq_df_acc_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [7:0] len, input logic [39:0] init,
                              input int stall, input int hold, input logic [39:0] exp);
    vec_t v;
    v.len = len; v.init = init; v.stall = stall; v.hold = hold; v.exp = exp;
    for (int i = 0; i < 16; i++) begin
      v.v1[i] = 16'd0;
      v.v2[i] = 16'd0;
    end
    return v;
  endfunction

  function automatic logic [39:0] model(input vec_t v);
    logic [39:0] acc;
    logic [39:0] d;
    acc = v.init;
    for (int i = 0; i < int'(v.len); i++) begin
      d = (v.v1[i] > v.v2[i]) ? 40'(v.v1[i] - v.v2[i]) : 40'(v.v2[i] - v.v1[i]);
      acc = acc + d * d;
    end
    return acc;
  endfunction

  task automatic start_job(input logic [7:0] len, input logic [39:0] init);
    bus.start = 1'b1; bus.vector_length = len; bus.init_acc = init;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  // Runs one complete job and checks latency, result, hold and return to IDLE.
  task automatic run_job(input vec_t v, input string tag,
                         input bit start_in_done, input bit abort_in_done);
    int idx;
    int cyc;
    int it;
    int lat;
    logic want;
    logic xfer;
    start_job(v.len, v.init);
    chk({tag, "_busy"}, 64'(bus.busy), 64'd1);
    idx = 0; cyc = 0; it = 0;
    while (idx < int'(v.len) && cyc < 400) begin
      case (v.stall)
        1:       want = (it % 2) == 1;
        2:       want = $urandom_range(0, 2) != 0;
        default: want = 1'b1;
      endcase
      bus.in_valid = want;
      bus.in_v1 = want ? v.v1[idx] : 16'hDEAD;
      bus.in_v2 = want ? v.v2[idx] : 16'hBEEF;
      xfer = want && bus.in_ready;
      @(negedge clk);
      if (xfer) idx++;
      it++; cyc++;
    end
    bus.in_valid = 1'b0;
    chk({tag, "_feed_done"}, 64'(idx), 64'(v.len));
    chk({tag, "_in_ready_low"}, 64'(bus.in_ready), 64'd0);
    lat = 1;
    while (!bus.result_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, "_latency"}, 64'(lat), 64'd4);
    chk({tag, "_result"}, 64'(bus.result), 64'(v.exp));
    for (int h = 0; h < v.hold; h++) begin
      if (start_in_done && h == 0) begin
        bus.start = 1'b1; bus.vector_length = 8'd3; bus.init_acc = 40'd0;
      end else begin
        bus.start = 1'b0;
      end
      @(negedge clk);
      chk({tag, "_hold"}, {23'd0, bus.result_valid, bus.result}, {23'd0, 1'b1, v.exp});
    end
    bus.start = 1'b0;
    if (abort_in_done) begin
      bus.abort = 1'b1;
      @(negedge clk);
      bus.abort = 1'b0;
    end else begin
      bus.result_ready = 1'b1;
      @(negedge clk);
      bus.result_ready = 1'b0;
    end
    chk({tag, "_to_idle"}, {62'd0, bus.busy, bus.result_valid}, 64'd0);
  endtask

  initial begin
    vec_t v;
    bus.start = 1'b0; bus.vector_length = 8'd0; bus.init_acc = 40'd0;
    bus.abort = 1'b0; bus.in_valid = 1'b0; bus.in_v1 = 16'd0; bus.in_v2 = 16'd0;
    bus.result_ready = 1'b0;

    vecs[0] = mk(8'd4, 40'd0, 0, 0, 40'd30);
    for (int i = 0; i < 4; i++) vecs[0].v1[i] = 16'(i + 1);
    vecs[1] = mk(8'd2, 40'd100, 1, 1, 40'd108);
    vecs[1].v1[0] = 16'd5; vecs[1].v2[0] = 16'd3;
    vecs[1].v1[1] = 16'd3; vecs[1].v2[1] = 16'd5;
    vecs[2] = mk(8'd3, 40'd5, 2, 2, 40'd136);
    vecs[2].v1[0] = 16'd10;    vecs[2].v2[0] = 16'd3;
    vecs[2].v1[1] = 16'd0;     vecs[2].v2[1] = 16'd9;
    vecs[2].v1[2] = 16'd65535; vecs[2].v2[2] = 16'd65534;
    vecs[3] = mk(8'd1, 40'hFF_FFFF_FFFF, 0, 0, 40'd3);
    vecs[3].v1[0] = 16'd2;
    vecs[4] = mk(8'd3, 40'd0, 1, 0, 40'd8589672450);
    vecs[4].v1[0] = 16'd65535; vecs[4].v2[1] = 16'd65535;
    vecs[4].v1[2] = 16'd100;   vecs[4].v2[2] = 16'd100;

    // Reset state
    @(negedge clk);
    chk("reset_outputs", {60'd0, bus.busy, bus.in_ready, bus.result_valid, 1'b0}, 64'd0);
    chk("reset_result", 64'(bus.result), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 5; i++) begin
      run_job(vecs[i], $sformatf("vec%0d", i), 1'b0, 1'b0);
    end

    // Long hold in DONE with an ignored start.
    v = vecs[0];
    v.hold = 5;
    run_job(v, "done_hold", 1'b1, 1'b0);
    @(negedge clk);
    chk("done_start_ignored", 64'(bus.busy), 64'd0);

    // Abort after 2 of 4 transfers.
    start_job(8'd4, 40'd0);
    bus.in_valid = 1'b1; bus.in_v1 = 16'd9; bus.in_v2 = 16'd1;
    @(negedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0; bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk("flush_busy", {61'd0, bus.busy, bus.in_ready, bus.result_valid}, 64'd4);
      @(negedge clk);
    end
    chk("flush_to_idle", {62'd0, bus.busy, bus.result_valid}, 64'd0);
    v = mk(8'd1, 40'd0, 0, 0, 40'd25);
    v.v1[0] = 16'd7; v.v2[0] = 16'd2;
    run_job(v, "after_abort", 1'b0, 1'b0);

    // Abort in DONE drops result_valid.
    run_job(vecs[1], "abort_done", 1'b0, 1'b1);

    // Abort together with start in IDLE: abort wins.
    bus.abort = 1'b1;
    start_job(8'd2, 40'd0);
    bus.abort = 1'b0;
    chk("abort_beats_start", 64'(bus.busy), 64'd0);

    // Reset mid-DRAIN.
    start_job(8'd2, 40'd0);
    bus.in_valid = 1'b1; bus.in_v1 = 16'd4; bus.in_v2 = 16'd0;
    @(negedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("midrst_flags", {61'd0, bus.busy, bus.in_ready, bus.result_valid}, 64'd0);
    chk("midrst_result", 64'(bus.result), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    start_job(8'd0, 40'd7);
    chk("len0_ignored_a", 64'(bus.busy), 64'd0);
    @(negedge clk);
    chk("len0_ignored_b", 64'(bus.busy), 64'd0);

    // Random jobs against the software model.
    for (int r = 0; r < 6; r++) begin
      v = mk(8'($urandom_range(1, 16)), {8'd0, 32'($urandom)}, 2, $urandom_range(0, 3), 40'd0);
      for (int i = 0; i < 16; i++) begin
        v.v1[i] = 16'($urandom);
        v.v2[i] = 16'($urandom);
      end
      v.exp = model(v);
      run_job(v, $sformatf("rand%0d", r), 1'b0, 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  // Absolute time bound for the whole run.
  initial begin
    #200000;
    $display("FAIL timeout: got no end expected end");
    $fatal(1);
  end
endmodule
